// File: rtl/mem_arbiter.sv
// Shares one single-port 32-bit BRAM between instruction fetch and load/store; sizes accesses into byte lanes.
// Latency: grant and BRAM access in cycle 0, rvalid pulse in cycle 2 (one access per 2 cycles at most).
// Backpressure: requests wait with gnt low while BUSY; data wins unless fetch has been starved STARVE_LIMIT times.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_di,
  input  logic [31:0]           bram_do
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            id_data_q, we_q, uns_q, err_q;
  logic [1:0]      size_q, off_q;
  logic            if_rvalid_q, d_rvalid_q, if_err_q, d_err_q;
  logic [31:0]     if_rdata_q, d_rdata_q;

  logic            grant, force_f, acc_we, acc_err, acc_ok;
  logic [31:0]     acc_addr;
  logic [1:0]      acc_size;
  logic [31:0]     rsp_data;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  // Arbitration, access decode and BRAM drive for the grant cycle
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    bram_en   = 1'b0;
    bram_addr = '0;
    bram_we   = 4'b0000;
    bram_di   = 32'h0;
    force_f   = (starve_q == LIMIT) && if_req;
    if (state_q == IDLE) begin
      d_gnt  = d_req && !force_f;
      if_gnt = if_req && !d_gnt;
    end
    grant    = d_gnt || if_gnt;
    acc_addr = d_gnt ? d_addr : if_addr;
    acc_size = d_gnt ? d_size : 2'b10;
    acc_we   = d_gnt && d_we;
    acc_err  = (acc_size == 2'b11)
            || (acc_size == 2'b01 && acc_addr[0])
            || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
            || (|acc_addr[31:ADDR_WIDTH+2]);
    acc_ok   = grant && !acc_err;
    if (grant) begin
      state_d = BUSY;
      if (if_gnt || !if_req) starve_d = '0;
      else if (starve_q != LIMIT) starve_d = starve_q + SW'(1);
    end
    if (state_q == BUSY) state_d = IDLE;
    if (acc_ok) begin
      bram_en   = 1'b1;
      bram_addr = acc_addr[ADDR_WIDTH+1:2];
      if (acc_we) begin
        case (acc_size)
          2'b00: begin
            bram_we = 4'b0001 << acc_addr[1:0];
            bram_di = {4{d_wdata[7:0]}};
          end
          2'b01: begin
            bram_we = acc_addr[1] ? 4'b1100 : 4'b0011;
            bram_di = {2{d_wdata[15:0]}};
          end
          default: begin
            bram_we = 4'b1111;
            bram_di = d_wdata;
          end
        endcase
      end
    end
  end

  // Lane select and extension of the BRAM word returned in BUSY
  always_comb begin
    rsp_data = 32'h0;
    lane_b   = bram_do[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? bram_do[31:16] : bram_do[15:0];
    if (!err_q && !we_q) begin
      case (size_q)
        2'b00:   rsp_data = {{24{!uns_q && lane_b[7]}}, lane_b};
        2'b01:   rsp_data = {{16{!uns_q && lane_h[15]}}, lane_h};
        default: rsp_data = bram_do;
      endcase
    end
  end

  // State, starvation counter and latched access attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      id_data_q <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (grant) begin
        id_data_q <= d_gnt;
        we_q      <= acc_we;
        uns_q     <= d_gnt && d_unsigned;
        err_q     <= acc_err;
        size_q    <= acc_size;
        off_q     <= acc_addr[1:0];
      end
    end
  end

  // Response registers: one-cycle rvalid pulse to the latched requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (state_q == BUSY) begin
        if (id_data_q) begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= rsp_data;
          d_err_q    <= err_q;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= rsp_data;
          if_err_q    <= err_q;
        end
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-first BRAM model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked before the next edge.
// Every step compares against hand-computed values.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        bram_en;
  logic [9:0]  bram_addr;
  logic [3:0]  bram_we;
  logic [31:0] bram_di, bram_do;

  logic [31:0] mem [1024];
  int nvec = 0;
  int nerr = 0;

  mem_arbiter #(.ADDR_WIDTH(10), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_we(bram_we),
    .bram_di(bram_di), .bram_do(bram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered read-first output, byte-lane writes; reset restores the preload
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      bram_do <= 32'h0;
    end else if (bram_en) begin
      bram_do <= mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_di[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data access: checks grant-cycle BRAM drive, BUSY cycle, then the response
  task automatic data_txn(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic en_x, input logic [9:0] ba_x, input logic [3:0] we_x,
                          input logic [31:0] di_x, input logic [31:0] rd_x, input logic err_x);
    d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    #1;
    chk({tag, ".gnt"}, {31'b0, d_gnt}, 32'd1);
    chk({tag, ".en"}, {31'b0, bram_en}, {31'b0, en_x});
    chk({tag, ".addr"}, {22'b0, bram_addr}, {22'b0, ba_x});
    chk({tag, ".we"}, {28'b0, bram_we}, {28'b0, we_x});
    chk({tag, ".di"}, bram_di, di_x);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
    #1;
    chk({tag, ".busy_rvalid"}, {31'b0, d_rvalid}, 32'd0);
    tick();
    chk({tag, ".rvalid"}, {31'b0, d_rvalid}, 32'd1);
    chk({tag, ".rdata"}, d_rdata, rd_x);
    chk({tag, ".err"}, {31'b0, d_err}, {31'b0, err_x});
  endtask

  task automatic fetch_txn(input string tag, input logic [31:0] addr,
                           input logic [31:0] rd_x, input logic err_x);
    if_req = 1'b1; if_addr = addr;
    #1;
    chk({tag, ".gnt"}, {31'b0, if_gnt}, 32'd1);
    chk({tag, ".en"}, {31'b0, bram_en}, {31'b0, !err_x});
    chk({tag, ".we"}, {28'b0, bram_we}, 32'd0);
    tick();
    if_req = 1'b0;
    tick();
    chk({tag, ".rvalid"}, {31'b0, if_rvalid}, 32'd1);
    chk({tag, ".rdata"}, if_rdata, rd_x);
    chk({tag, ".err"}, {31'b0, if_err}, {31'b0, err_x});
  endtask

  initial begin
    logic [1:0] exp_seq [6];
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) tick();
    chk("rst.if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst.d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rst.if_rdata", if_rdata, 32'h0);
    chk("rst.d_rdata", d_rdata, 32'h0);
    chk("rst.bram_en", {31'b0, bram_en}, 32'd0);
    chk("rst.bram_we", {28'b0, bram_we}, 32'd0);
    rst = 1'b0;
    tick();

    fetch_txn("fetch10", 32'h10, 32'hDEADBEEF, 1'b0);
    // byte store at 0x13: lane 3, data replicated
    data_txn("stb13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5,
             1'b1, 10'd4, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);
    data_txn("ldb13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,
             1'b1, 10'd4, 4'b0000, 32'h0, 32'hFFFFFFA5, 1'b0);
    data_txn("ldb13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,
             1'b1, 10'd4, 4'b0000, 32'h0, 32'h000000A5, 1'b0);
    data_txn("sth22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001,
             1'b1, 10'd8, 4'b1100, 32'h80018001, 32'h0, 1'b0);
    data_txn("ldh22s", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0,
             1'b1, 10'd8, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
    // word 4 is now A5ADBEEF; upper half at 0x12, zero-extended
    data_txn("ldh12u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,
             1'b1, 10'd4, 4'b0000, 32'h0, 32'h0000A5AD, 1'b0);
    data_txn("ldw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
             1'b1, 10'd4, 4'b0000, 32'h0, 32'hA5ADBEEF, 1'b0);
    // illegal accesses: no BRAM activity, err response
    data_txn("ldw02", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0,
             1'b0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1);
    data_txn("ldh05", 1'b0, 2'b01, 1'b0, 32'h5, 32'h0,
             1'b0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1);
    data_txn("ldw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,
             1'b0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1);
    data_txn("stsz3", 1'b1, 2'b11, 1'b0, 32'h8, 32'h12345678,
             1'b0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1);
    data_txn("stw2", 1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678,
             1'b0, 10'd0, 4'b0000, 32'h0, 32'h0, 1'b1);
    fetch_txn("fetch12", 32'h12, 32'h0, 1'b1);
    data_txn("ldwlast", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0,
             1'b1, 10'd1023, 4'b0000, 32'h0, 32'h0, 1'b0);

    // both requesters held: D D F D D F, never a grant while BUSY
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b10; exp_seq[4] = 2'b10; exp_seq[5] = 2'b01;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("arb.g%0d", k), {30'b0, d_gnt, if_gnt}, {30'b0, exp_seq[k]});
      tick();
      chk($sformatf("arb.busy%0d", k), {30'b0, d_gnt, if_gnt}, 32'd0);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("arb.if_rdata", if_rdata, 32'hA5ADBEEF);
    chk("arb.d_rdata", d_rdata, 32'h80010000);

    // reset while a load is in flight
    d_req = 1'b1; d_size = 2'b10; d_addr = 32'h10;
    #1;
    chk("rstb.gnt", {31'b0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstb.d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rstb.d_rdata", d_rdata, 32'h0);
    chk("rstb.if_rdata", if_rdata, 32'h0);
    chk("rstb.bram_en", {31'b0, bram_en}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstb.quiet%0d", k), {30'b0, d_rvalid, if_rvalid}, 32'd0);
      tick();
    end
    fetch_txn("fetch_after_rst", 32'h10, 32'hDEADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
